// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32 load/store unit bridging the core datapath to a
//            req/gnt/rvalid memory bus, with alignment checks and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_rdata;
    logic [15:0] r_count;
    logic        r_bus_err;

    logic        w_access;
    logic        w_fault;
    logic        w_start;
    logic        w_complete;
    logic        w_timeout;
    logic        w_count_hit;
    logic        w_stall;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_access    = mem_read | mem_write;
    assign w_count_hit = (r_count + 16'd1) == c_TIMEOUT;

    // Stores only exist in signed-width encodings; the unsigned load codes are illegal for them.
    always_comb begin
        w_fault = 1'b0;
        case (funct3)
            3'b000:         w_fault = 1'b0;
            3'b001:         w_fault = addr[0];
            3'b010:         w_fault = (addr[1:0] != 2'b00);
            3'b100:         w_fault = mem_write;
            3'b101:         w_fault = mem_write | addr[0];
            default:        w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << addr[1:0];
                w_wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be        = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        w_byte      = bus_rdata[{r_addr_lo, 3'b000} +: 8];
        w_half      = bus_rdata[{r_addr_lo[1], 4'b0000} +: 16];
        w_load_data = bus_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = bus_rdata;
        endcase
    end

    // Timeout outranks any grant or response arriving in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_misaligned = 1'b0;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_fault) begin
                        w_misaligned = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_stall      = 1'b1;
                        w_state_next = REQ;
                    end
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (w_count_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end else if (bus_gnt && bus_rvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end else if (bus_gnt) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (w_count_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end else if (bus_rvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_rdata     <= 32'd0;
            r_count     <= 16'd0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bus_err <= w_timeout;

            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_write;
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_be    <= mem_write ? w_be : 4'b0000;
                r_bus_wdata <= w_wdata_rep;
                r_funct3    <= funct3;
                r_addr_lo   <= addr[1:0];
            end else if (r_state == REQ && w_state_next != REQ) begin
                r_bus_req <= 1'b0;
            end

            if (w_start) begin
                r_count <= 16'd0;
            end else if (r_state == REQ || r_state == WAIT) begin
                r_count <= r_count + 16'd1;
            end

            if (w_timeout) begin
                r_rdata <= 32'd0;
            end else if (w_complete && !r_bus_we) begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign stall      = reset ? w_stall : 1'b0;
    assign misaligned = reset ? w_misaligned : 1'b0;
    assign bus_err    = r_bus_err;
    assign rdata      = (r_state == DONE) ? r_rdata : 32'd0;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_be     = r_bus_be;
    assign bus_wdata  = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit against a behavioural
//            model of alignment, lane steering, extension and timeout rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_rdata_q;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access size in bytes, 0 for an encoding with no meaning.
    function automatic int model_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = model_size(f3);
        if (sz == 0) return 1'b1;
        if (wr && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = model_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (model_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        int          sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz   = model_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (d >> (8 * (a % 4))) & mask;
        if (f3 < 3'b100 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access: gnt arrives gnt_lat cycles into REQ, rvalid rv_lat cycles after gnt.
    task automatic run_access(input string tag, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                              input int gnt_lat, input int rv_lat, input bit stray,
                              output int stall_cycles);
        bit          exp_fault;
        bit          exp_to;
        int          c_done;
        int          end_c;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        exp_fault    = model_fault(wr, f3, a);
        c_done       = gnt_lat + rv_lat;
        exp_to       = (c_done > T - 2);
        end_c        = exp_to ? T - 1 : c_done;
        exp_be       = wr ? model_be(f3, a) : 4'b0000;
        stall_cycles = 0;

        @(negedge clk);
        mem_read   = !wr;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        wdata      = wd;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        #1;
        stall_cycles += int'(stall);
        n_checks++;
        if (misaligned !== exp_fault || stall !== !exp_fault || rdata !== 32'd0 || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle: misaligned=%b stall=%b rdata=%h bus_req=%b, expected misaligned=%b stall=%b rdata=0 bus_req=0",
                     tag, misaligned, stall, rdata, bus_req, exp_fault, !exp_fault);
        end

        if (exp_fault) begin
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            n_checks++;
            if (bus_req !== 1'b0 || misaligned !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
                n_errors++;
                $display("FAIL %s after fault: bus_req=%b misaligned=%b stall=%b bus_err=%b, expected all 0",
                         tag, bus_req, misaligned, stall, bus_err);
            end
            return;
        end

        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            bus_gnt    = (c == gnt_lat);
            bus_rvalid = (c == c_done) || (stray && c < gnt_lat);
            bus_rdata  = (c == c_done) ? brd : $urandom;
            #1;
            stall_cycles += int'(stall);
            n_checks++;
            if (stall !== 1'b1 || rdata !== 32'd0 || bus_err !== 1'b0 || misaligned !== 1'b0) begin
                n_errors++;
                $display("FAIL %s busy c=%0d: stall=%b rdata=%h bus_err=%b misaligned=%b, expected stall=1 rdata=0 bus_err=0 misaligned=0",
                         tag, c, stall, rdata, bus_err, misaligned);
            end
            n_checks++;
            if (c <= gnt_lat) begin
                if (bus_req !== 1'b1 || bus_we !== wr || bus_addr !== (a & 32'hFFFF_FFFC) ||
                    bus_be !== exp_be || (wr && bus_wdata !== model_wdata(f3, wd))) begin
                    n_errors++;
                    $display("FAIL %s req c=%0d: req=%b we=%b addr=%h be=%b wdata=%h, expected req=1 we=%b addr=%h be=%b wdata=%h",
                             tag, c, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                             wr, a & 32'hFFFF_FFFC, exp_be, model_wdata(f3, wd));
                end
            end else if (bus_req !== 1'b0) begin
                n_errors++;
                $display("FAIL %s wait c=%0d: bus_req=%b, expected 0", tag, c, bus_req);
            end
        end

        if (exp_to)      exp_rdata = 32'd0;
        else if (wr)     exp_rdata = m_rdata_q;
        else             exp_rdata = model_load(f3, a, brd);
        m_rdata_q = exp_rdata;

        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        #1;
        stall_cycles += int'(stall);
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || bus_err !== exp_to || rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL %s done: stall=%b bus_req=%b bus_err=%b rdata=%h, expected stall=0 bus_req=0 bus_err=%b rdata=%h",
                     tag, stall, bus_req, bus_err, rdata, exp_to, exp_rdata);
        end

        // Request inputs were still high in DONE; no new access may have started.
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL %s back to idle: stall=%b bus_req=%b bus_err=%b rdata=%h, expected all 0",
                     tag, stall, bus_req, bus_err, rdata);
        end
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0000_0010;
        wdata      = 32'hDEAD_BEEF;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0 || misaligned !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'd0 ||
            bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'd0 || bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset outputs: stall=%b mis=%b err=%b rdata=%h req=%b we=%b be=%b addr=%h wdata=%h, expected all 0",
                     stall, misaligned, bus_err, rdata, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        @(negedge clk);
        reset    = 1'b1;
        mem_read = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset release: stall=%b bus_req=%b rdata=%h, expected 0 0 0", stall, bus_req, rdata);
        end
        m_rdata_q = 32'd0;
    endtask

    task automatic test_load_sign;
        int sc;
        run_access("lb_sign", 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF00, 0, 1, 1'b0, sc);
        n_checks++;
        if (sc !== 3) begin
            n_errors++;
            $display("FAIL lb_sign stall_cycles: got %0d, expected 3", sc);
        end
    endtask

    task automatic test_store_half;
        int sc;
        run_access("sh_store", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 1, 2, 1'b1, sc);
    endtask

    task automatic test_faults;
        int         sc;
        logic [2:0] f3s   [10] = '{3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111, 3'b100, 3'b101, 3'b010, 3'b001};
        bit         wrs   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] offs  [10] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3};
        for (int i = 0; i < 10; i++) begin
            run_access("fault", wrs[i], f3s[i], {28'h000_0000, 2'b01, offs[i]}, 32'h0, 32'h0, 0, 1, 1'b0, sc);
        end
    endtask

    task automatic test_fast_lhu;
        int sc;
        run_access("lhu_fast", 1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'hBEEF_0000, 0, 0, 1'b0, sc);
        n_checks++;
        if (sc !== 2) begin
            n_errors++;
            $display("FAIL lhu_fast stall_cycles: got %0d, expected 2", sc);
        end
    endtask

    task automatic test_timeout;
        int sc;
        run_access("timeout_nognt", 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_2222, 99, 0, 1'b0, sc);
        n_checks++;
        if (sc !== T + 1) begin
            n_errors++;
            $display("FAIL timeout stall_cycles: got %0d, expected %0d", sc, T + 1);
        end
        run_access("timeout_late_rvalid", 1'b0, 3'b010, 32'h0000_0044, 32'd0, 32'h3333_4444, 1, 2, 1'b0, sc);
        run_access("store_after_timeout", 1'b1, 3'b000, 32'h0000_0045, 32'h0000_0077, 32'd0, 0, 1, 1'b0, sc);
    endtask

    task automatic test_reset_mid;
        int sc;
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0080;
        #1;
        @(negedge clk);
        bus_gnt = 1'b1;
        #1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid wait: stall=%b bus_req=%b, expected 1 0", stall, bus_req);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'd0 || bus_addr !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid asserted: stall=%b bus_req=%b rdata=%h bus_addr=%h, expected 0 0 0 0",
                     stall, bus_req, rdata, bus_addr);
        end
        @(negedge clk);
        reset    = 1'b1;
        mem_read = 1'b0;
        #1;
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFE_F00D;
        #1;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'd0 || bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid stray rvalid: stall=%b bus_req=%b rdata=%h bus_err=%b, expected all 0",
                     stall, bus_req, rdata, bus_err);
        end
        m_rdata_q = 32'd0;
        run_access("after_reset_store", 1'b1, 3'b010, 32'h0000_0100, 32'hA5A5_5A5A, 32'd0, 0, 1, 1'b0, sc);
    endtask

    task automatic test_random;
        int sc;
        for (int i = 0; i < 60; i++) begin
            run_access("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                       $urandom, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), sc);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_rdata_q = 32'd0;
        test_reset();
        test_load_sign();
        test_store_half();
        test_faults();
        test_fast_lhu();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
